// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle main controller: opcodes, functs, ALU codes,
// datapath mux selects, FSM states and the decoded-instruction record.
package multicycle_control_pkg;

  localparam int unsigned WAIT_W = 16;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_R_ARITH = 4'd1,
    CLS_R_SHIFT = 4'd2,
    CLS_R_LOGIC = 4'd3,
    CLS_IMM     = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_BRANCH  = 4'd7,
    CLS_JUMP    = 4'd8,
    CLS_LUI     = 4'd9
  } instr_class_e;

  localparam logic [3:0] ALU_NONE    = 4'd0;
  localparam logic [3:0] ALU_ADD     = 4'd1;
  localparam logic [3:0] ALU_SUB     = 4'd2;
  localparam logic [3:0] ALU_AND     = 4'd3;
  localparam logic [3:0] ALU_OR      = 4'd4;
  localparam logic [3:0] ALU_XOR     = 4'd5;
  localparam logic [3:0] ALU_SLL     = 4'd6;
  localparam logic [3:0] ALU_SRA     = 4'd7;
  localparam logic [3:0] ALU_R_ARITH = 4'd8;
  localparam logic [3:0] ALU_R_SHIFT = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;
  localparam logic [1:0] MTR_LUI    = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    instr_class_e cls;
    logic [3:0]   alu_op;
    logic [1:0]   alu_flag;
    logic         ext_sign;
    logic         is_bne;
    logic         is_jal;
    logic         is_jr;
  } decode_t;

  // The low funct bits tell the ALU control decoder which R-type variant to run.
  function automatic logic [1:0] r_qualifier(input logic [5:0] funct);
    return funct[1:0];
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; the controller is the master side.
interface multicycle_control_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        zero;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        ext_sign;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic [1:0]  alu_flag;
  logic        illegal;

  modport master (
    input  instr, mem_ready, zero,
    output pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, ext_sign, alu_src_a, alu_src_b, alu_op, alu_flag, illegal
  );

  modport slave (
    output instr, mem_ready, zero,
    input  pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, ext_sign, alu_src_a, alu_src_b, alu_op, alu_flag, illegal
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational instruction classifier: opcode/funct -> class plus the EXEC-stage
// ALU op, function qualifier and immediate extension mode.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output decode_t    dec
);

  // Classify the instruction and pick its EXEC ALU controls.
  always_comb begin
    dec     = '0;
    dec.cls = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: begin
            dec.cls      = CLS_R_ARITH;
            dec.alu_op   = ALU_R_ARITH;
            dec.alu_flag = r_qualifier(funct);
          end
          FN_SLL, FN_SRA: begin
            dec.cls      = CLS_R_SHIFT;
            dec.alu_op   = ALU_R_SHIFT;
            dec.alu_flag = r_qualifier(funct);
          end
          FN_AND: begin dec.cls = CLS_R_LOGIC; dec.alu_op = ALU_AND; end
          FN_OR:  begin dec.cls = CLS_R_LOGIC; dec.alu_op = ALU_OR;  end
          FN_XOR: begin dec.cls = CLS_R_LOGIC; dec.alu_op = ALU_XOR; end
          FN_JR:  begin dec.cls = CLS_JUMP;    dec.is_jr  = 1'b1;    end
          default: dec.cls = CLS_ILLEGAL;
        endcase
      end
      OP_J:     dec.cls = CLS_JUMP;
      OP_JAL:   begin dec.cls = CLS_JUMP;   dec.is_jal = 1'b1; end
      OP_BEQ:   begin dec.cls = CLS_BRANCH; dec.alu_op = ALU_SUB; end
      OP_BNE:   begin dec.cls = CLS_BRANCH; dec.alu_op = ALU_SUB; dec.is_bne = 1'b1; end
      OP_ADDIU: begin dec.cls = CLS_IMM;    dec.alu_op = ALU_ADD; dec.ext_sign = 1'b1; end
      OP_ANDI:  begin dec.cls = CLS_IMM;    dec.alu_op = ALU_AND; end
      OP_ORI:   begin dec.cls = CLS_IMM;    dec.alu_op = ALU_OR;  end
      OP_XORI:  begin dec.cls = CLS_IMM;    dec.alu_op = ALU_XOR; end
      OP_LUI:   dec.cls = CLS_LUI;
      OP_LW:    begin dec.cls = CLS_LOAD;   dec.alu_op = ALU_ADD; dec.ext_sign = 1'b1; end
      OP_SW:    begin dec.cls = CLS_STORE;  dec.alu_op = ALU_ADD; dec.ext_sign = 1'b1; end
      default:  dec.cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath
// selects, enables and the memory handshake, with an optional memory-wait timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  localparam logic              TIMEOUT_EN = (MEM_TIMEOUT != 32'd0);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 32'd1);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(32'd1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  decode_t           dec_s;
  logic              waiting_s;
  logic              timeout_s;

  multicycle_control_decode u_decode (
    .opcode (bus.instr[31:26]),
    .funct  (bus.instr[5:0]),
    .dec    (dec_s)
  );

  // The timeout fires in the last allowed wait cycle if memory still has not answered.
  assign waiting_s = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timeout_s = TIMEOUT_EN && waiting_s && !bus.mem_ready && (wait_cnt_q == WAIT_LAST);

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= {WAIT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = {WAIT_W{1'b0}};
    case (state_q)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout_s) begin
          state_d = ST_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ST_DECODE: begin
        case (dec_s.cls)
          CLS_JUMP, CLS_ILLEGAL: state_d = ST_FETCH;
          CLS_LUI:               state_d = ST_WB;
          default:               state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (dec_s.cls)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH:          state_d = ST_FETCH;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          state_d = (dec_s.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        end else if (timeout_s) begin
          state_d = ST_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // Datapath controls, decoded from state and instruction; all held low during reset.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_SRC_ALU;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = REG_DST_RT;
    bus.mem_to_reg = MTR_ALUOUT;
    bus.ext_sign   = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REG;
    bus.alu_op     = ALU_NONE;
    bus.alu_flag   = 2'b00;
    bus.illegal    = 1'b0;
    if (rst) begin
      bus.illegal = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.alu_op    = ALU_ADD;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
          end else begin
            bus.illegal = timeout_s;
          end
        end
        ST_DECODE: begin
          bus.alu_src_b = SRCB_IMM_SH;
          bus.ext_sign  = 1'b1;
          bus.alu_op    = ALU_ADD;
          case (dec_s.cls)
            CLS_JUMP: begin
              bus.pc_write = 1'b1;
              bus.pc_src   = dec_s.is_jr ? PC_SRC_RS : PC_SRC_JUMP;
              if (dec_s.is_jal) begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = REG_DST_R31;
                bus.mem_to_reg = MTR_PC;
              end else begin
                bus.reg_write = 1'b0;
              end
            end
            CLS_ILLEGAL: bus.illegal = 1'b1;
            default:     bus.illegal = 1'b0;
          endcase
        end
        ST_EXEC: begin
          bus.alu_op    = dec_s.alu_op;
          bus.alu_flag  = dec_s.alu_flag;
          bus.ext_sign  = dec_s.ext_sign;
          bus.alu_src_a = 1'b1;
          case (dec_s.cls)
            CLS_IMM, CLS_LOAD, CLS_STORE: bus.alu_src_b = SRCB_IMM;
            CLS_BRANCH: begin
              bus.pc_src   = PC_SRC_ALUOUT;
              bus.pc_write = dec_s.is_bne ? !bus.zero : bus.zero;
            end
            default: bus.alu_src_b = SRCB_REG;
          endcase
        end
        ST_MEM: begin
          bus.iord      = 1'b1;
          bus.mem_read  = (dec_s.cls == CLS_LOAD);
          bus.mem_write = (dec_s.cls == CLS_STORE);
          bus.illegal   = timeout_s;
        end
        ST_WB: begin
          bus.reg_write = 1'b1;
          case (dec_s.cls)
            CLS_R_ARITH, CLS_R_SHIFT, CLS_R_LOGIC: bus.reg_dst = REG_DST_RD;
            CLS_LOAD: bus.mem_to_reg = MTR_MDR;
            CLS_LUI:  bus.mem_to_reg = MTR_LUI;
            default:  bus.reg_dst    = REG_DST_RT;
          endcase
        end
        default: bus.illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-mnemonic expected control traces compared every cycle,
// plus literal spot checks on cycle counts and key control fields.
module tb_multicycle_control;

  localparam int TMO = 4;

  typedef enum int {
    M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLL, M_SRA, M_JR, M_BADR,
    M_J, M_JAL, M_BEQ, M_BNE, M_ADDIU, M_ANDI, M_ORI, M_XORI, M_LUI,
    M_LW, M_SW, M_BAD
  } mn_e;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       ext_sign;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] alu_flag;
    logic       illegal;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  multicycle_control_if bus();

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  ctl_t  act, exp_q, last_act, snap_f0, snap_flast, snap_dec, snap_exec, snap_wb;
  logic  exp_v = 1'b0;
  string tag = "idle";
  int    checks = 0;
  int    failures = 0;
  int    n_regw, n_mem, n_ill;
  mn_e   misc_q[$] = '{M_SUBU, M_AND, M_OR, M_XOR, M_ADDIU, M_ANDI, M_ORI, M_XORI,
                       M_LUI, M_J, M_JAL, M_JR, M_BADR};

  always_comb begin
    act            = '0;
    act.pc_write   = bus.pc_write;
    act.pc_src     = bus.pc_src;
    act.ir_write   = bus.ir_write;
    act.iord       = bus.iord;
    act.mem_read   = bus.mem_read;
    act.mem_write  = bus.mem_write;
    act.reg_write  = bus.reg_write;
    act.reg_dst    = bus.reg_dst;
    act.mem_to_reg = bus.mem_to_reg;
    act.ext_sign   = bus.ext_sign;
    act.alu_src_a  = bus.alu_src_a;
    act.alu_src_b  = bus.alu_src_b;
    act.alu_op     = bus.alu_op;
    act.alu_flag   = bus.alu_flag;
    act.illegal    = bus.illegal;
  end

  // Single per-cycle compare against the expected trace.
  always @(negedge clk) begin
    if (exp_v) begin
      checks++;
      if (act !== exp_q) begin
        failures++;
        $display("FAIL cyc_%s actual=%h expected=%h t=%0t", tag, act, exp_q, $time);
      end
    end
  end

  task automatic chk(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, a, e);
    end
  endtask

  function automatic logic [31:0] enc(input mn_e mn);
    case (mn)
      M_ADDU:  enc = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001};
      M_SUBU:  enc = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100011};
      M_AND:   enc = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100100};
      M_OR:    enc = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100101};
      M_XOR:   enc = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100110};
      M_SLL:   enc = {6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'b000000};
      M_SRA:   enc = {6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'b000011};
      M_JR:    enc = {6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'b001000};
      M_BADR:  enc = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b101010};
      M_J:     enc = {6'b000010, 26'd64};
      M_JAL:   enc = {6'b000011, 26'd64};
      M_BEQ:   enc = {6'b000100, 5'd1, 5'd2, 16'd3};
      M_BNE:   enc = {6'b000101, 5'd1, 5'd2, 16'd3};
      M_ADDIU: enc = {6'b001001, 5'd1, 5'd2, 16'hfff0};
      M_ANDI:  enc = {6'b001100, 5'd1, 5'd2, 16'h00ff};
      M_ORI:   enc = {6'b001101, 5'd1, 5'd2, 16'h00ff};
      M_XORI:  enc = {6'b001110, 5'd1, 5'd2, 16'h00ff};
      M_LUI:   enc = {6'b001111, 5'd0, 5'd2, 16'h1234};
      M_LW:    enc = {6'b100011, 5'd29, 5'd2, 16'd8};
      M_SW:    enc = {6'b101011, 5'd29, 5'd2, 16'd8};
      default: enc = {6'b111111, 26'd0};
    endcase
  endfunction

  function automatic logic is_rtype(input mn_e mn);
    return mn inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLL, M_SRA};
  endfunction

  function automatic ctl_t m_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'b01;
    c.alu_op    = 4'd1;
    c.ir_write  = rdy;
    c.pc_write  = rdy;
    return c;
  endfunction

  function automatic ctl_t m_decode(input mn_e mn);
    ctl_t c = '0;
    c.alu_src_b = 2'b11;
    c.ext_sign  = 1'b1;
    c.alu_op    = 4'd1;
    case (mn)
      M_J:   begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
      M_JAL: begin c.pc_write = 1'b1; c.pc_src = 2'b10; c.reg_write = 1'b1;
                   c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; end
      M_JR:  begin c.pc_write = 1'b1; c.pc_src = 2'b11; end
      M_BAD, M_BADR: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t m_exec(input mn_e mn, input logic z);
    ctl_t c = '0;
    c.alu_src_a = 1'b1;
    case (mn)
      M_ADDU:  begin c.alu_op = 4'd8; c.alu_flag = 2'b01; end
      M_SUBU:  begin c.alu_op = 4'd8; c.alu_flag = 2'b11; end
      M_AND:   c.alu_op = 4'd3;
      M_OR:    c.alu_op = 4'd4;
      M_XOR:   c.alu_op = 4'd5;
      M_SLL:   begin c.alu_op = 4'd9; c.alu_flag = 2'b00; end
      M_SRA:   begin c.alu_op = 4'd9; c.alu_flag = 2'b11; end
      M_ADDIU: begin c.alu_op = 4'd1; c.ext_sign = 1'b1; c.alu_src_b = 2'b10; end
      M_ANDI:  begin c.alu_op = 4'd3; c.alu_src_b = 2'b10; end
      M_ORI:   begin c.alu_op = 4'd4; c.alu_src_b = 2'b10; end
      M_XORI:  begin c.alu_op = 4'd5; c.alu_src_b = 2'b10; end
      M_LW, M_SW: begin c.alu_op = 4'd1; c.ext_sign = 1'b1; c.alu_src_b = 2'b10; end
      M_BEQ:   begin c.alu_op = 4'd2; c.pc_src = 2'b01; c.pc_write = z; end
      M_BNE:   begin c.alu_op = 4'd2; c.pc_src = 2'b01; c.pc_write = !z; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t m_mem(input mn_e mn);
    ctl_t c = '0;
    c.iord      = 1'b1;
    c.mem_read  = (mn == M_LW);
    c.mem_write = (mn == M_SW);
    return c;
  endfunction

  function automatic ctl_t m_wb(input mn_e mn);
    ctl_t c = '0;
    c.reg_write = 1'b1;
    if (is_rtype(mn)) c.reg_dst = 2'b01;
    if (mn == M_LW) c.mem_to_reg = 2'b01;
    if (mn == M_LUI) c.mem_to_reg = 2'b11;
    return c;
  endfunction

  // One clock cycle: drive inputs, publish the expectation, snapshot outputs mid-cycle.
  task automatic cyc(input string t, input ctl_t e, input logic rdy, input logic z, input logic r);
    rst           = r;
    bus.mem_ready = rdy;
    bus.zero      = z;
    exp_q         = e;
    exp_v         = 1'b1;
    tag           = t;
    #2;
    last_act = act;
    n_regw  += int'(act.reg_write);
    n_mem   += int'(act.iord && (act.mem_read || act.mem_write));
    n_ill   += int'(act.illegal);
    @(posedge clk);
    #1;
  endtask

  // Walk one instruction through its expected phase sequence; n = cycles spent.
  task automatic run_instr(input mn_e mn, input int fw, input int mw, input logic z, output int n);
    ctl_t e;
    logic done;
    n = 0; n_regw = 0; n_mem = 0; n_ill = 0; done = 1'b0;
    for (int i = 0; i <= fw && !done; i++) begin
      e = m_fetch(i == fw);
      if (i != fw && i == TMO - 1) begin
        e.illegal = 1'b1;
        done      = 1'b1;
      end
      cyc("fetch", e, i == fw, z, 1'b0);
      if (n == 0) snap_f0 = last_act;
      snap_flast = last_act;
      n++;
    end
    if (done) return;
    bus.instr = enc(mn);
    cyc("decode", m_decode(mn), 1'b0, z, 1'b0); n++; snap_dec = last_act;
    if (mn inside {M_J, M_JAL, M_JR, M_BAD, M_BADR}) return;
    if (mn != M_LUI) begin
      cyc("exec", m_exec(mn, z), 1'b0, z, 1'b0); n++; snap_exec = last_act;
      if (mn inside {M_BEQ, M_BNE}) return;
      if (mn inside {M_LW, M_SW}) begin
        for (int i = 0; i <= mw && !done; i++) begin
          e = m_mem(mn);
          if (i != mw && i == TMO - 1) begin
            e.illegal = 1'b1;
            done      = 1'b1;
          end
          cyc("mem", e, i == mw, z, 1'b0); n++;
        end
        if (done || mn == M_SW) return;
      end
    end
    cyc("wb", m_wb(mn), 1'b0, z, 1'b0); n++; snap_wb = last_act;
  endtask

  initial begin
    int n;
    rst = 1'b1; bus.instr = 32'd0; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    @(posedge clk); #1;

    cyc("reset", '0, 1'b1, 1'b0, 1'b1);
    cyc("reset", '0, 1'b1, 1'b0, 1'b1);
    chk("reset_outputs_zero", int'(last_act), 0);

    run_instr(M_ADDU, 3, 0, 1'b0, n);
    chk("addu_total_cycles", n, 7);
    chk("first_fetch_mem_read", int'(snap_f0.mem_read), 1);
    chk("first_fetch_iord", int'(snap_f0.iord), 0);
    chk("first_fetch_alu_src_b", int'(snap_f0.alu_src_b), 1);
    chk("first_fetch_alu_op", int'(snap_f0.alu_op), 1);
    chk("first_fetch_ir_write", int'(snap_f0.ir_write), 0);
    chk("fourth_fetch_ir_write", int'(snap_flast.ir_write), 1);
    chk("fourth_fetch_pc_write", int'(snap_flast.pc_write), 1);
    chk("addu_exec_alu_op", int'(snap_exec.alu_op), 8);
    chk("addu_exec_alu_flag", int'(snap_exec.alu_flag), 1);
    chk("addu_wb_reg_write", int'(snap_wb.reg_write), 1);
    chk("addu_wb_reg_dst", int'(snap_wb.reg_dst), 1);

    run_instr(M_SRA, 0, 0, 1'b0, n);
    chk("sra_exec_alu_op", int'(snap_exec.alu_op), 9);
    chk("sra_exec_alu_flag", int'(snap_exec.alu_flag), 3);
    run_instr(M_SLL, 0, 0, 1'b0, n);
    chk("sll_exec_alu_op", int'(snap_exec.alu_op), 9);
    chk("sll_exec_alu_flag", int'(snap_exec.alu_flag), 0);

    run_instr(M_LW, 1, 2, 1'b0, n);
    chk("lw_total_cycles", n, 8);
    chk("lw_mem_read_cycles", n_mem, 3);
    chk("lw_wb_mem_to_reg", int'(snap_wb.mem_to_reg), 1);
    run_instr(M_SW, 0, 2, 1'b0, n);
    chk("sw_total_cycles", n, 6);
    chk("sw_mem_write_cycles", n_mem, 3);
    chk("sw_no_reg_write", n_regw, 0);

    run_instr(M_BEQ, 0, 0, 1'b1, n);
    chk("beq_z1_pc_write", int'(snap_exec.pc_write), 1);
    chk("beq_z1_pc_src", int'(snap_exec.pc_src), 1);
    run_instr(M_BEQ, 0, 0, 1'b0, n);
    chk("beq_z0_pc_write", int'(snap_exec.pc_write), 0);
    run_instr(M_BNE, 0, 0, 1'b1, n);
    chk("bne_z1_pc_write", int'(snap_exec.pc_write), 0);
    run_instr(M_BNE, 0, 0, 1'b0, n);
    chk("bne_z0_pc_write", int'(snap_exec.pc_write), 1);

    foreach (misc_q[k]) run_instr(misc_q[k], k % 3, 0, 1'b0, n);

    run_instr(M_BAD, 0, 0, 1'b0, n);
    chk("bad_opcode_cycles", n, 2);
    chk("bad_opcode_illegal", int'(snap_dec.illegal), 1);

    run_instr(M_LW, 0, 10, 1'b0, n);
    chk("mem_timeout_cycles", n, 7);
    chk("mem_timeout_req_cycles", n_mem, 4);
    chk("mem_timeout_illegal", n_ill, 1);
    chk("mem_timeout_no_reg_write", n_regw, 0);

    run_instr(M_ADDU, 10, 0, 1'b0, n);
    chk("fetch_timeout_cycles", n, 4);
    chk("fetch_timeout_illegal", n_ill, 1);

    // Reset while a store waits in MEM: no write in the reset cycle, then back to FETCH.
    cyc("fetch", m_fetch(1'b1), 1'b1, 1'b0, 1'b0);
    bus.instr = enc(M_SW);
    cyc("decode", m_decode(M_SW), 1'b0, 1'b0, 1'b0);
    cyc("exec", m_exec(M_SW, 1'b0), 1'b0, 1'b0, 1'b0);
    cyc("mem", m_mem(M_SW), 1'b0, 1'b0, 1'b0);
    cyc("rst_mid_mem", '0, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_mem_write", int'(last_act.mem_write), 0);
    run_instr(M_ADDU, 0, 0, 1'b0, n);
    chk("after_rst_addu_cycles", n, 4);

    exp_v = 1'b0;
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
